// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed seven-segment display slice:
//   - src_e      : source select codes for the display mux
//   - SEG_BLANK  : active-low segment word with every segment (and dp) dark
//   - SEG_ZERO   : active-low segment word showing "0" with dp dark
//   - NUM_DIGITS : number of multiplexed digits on the display
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment order is {dp, g, f, e, d, c, b, a}; a 0 lights the segment.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    // Codes 5..7 are unassigned and fall back to the hex display word.
    typedef enum logic [2:0] {
        SRC_HEX   = 3'd0,
        SRC_R     = 3'd1,
        SRC_I     = 3'd2,
        SRC_J     = 3'd3,
        SRC_TOTAL = 3'd4
    } src_e;

endpackage

// File: rtl/seg7_scan_display_decoder.sv
// -----------------------------------------------------------------------------
// hex7seg_decoder
// Combinational hex digit to seven-segment pattern, active-low.
// Ports:
//   nibble  in   4  hex digit 0..F
//   pattern out  7  active-low segments {g, f, e, d, c, b, a}
// Letters use the usual mixed-case forms: A, b, C, d, E, F.
// -----------------------------------------------------------------------------
module hex7seg_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        pattern = SEG_BLANK[6:0];
        case (nibble)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            4'hF: pattern = 7'h0E;
            default: pattern = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
// Drives an 8-digit multiplexed common-anode seven-segment display from one of
// five 32-bit sources. The displayed word is latched once per refresh frame
// (on the digit 7 -> 0 step) so a digit never shows a half-updated value.
//
// Parameters:
//   CLK_DIV        clk cycles per digit slot (>= 1)
//   BLANK_LEADING  1 = dark leading-zero digits, 0 = show all 8
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   hex_in       in   32  syscall display word
//   stat_r       in   32  R-type instruction count
//   stat_i       in   32  I-type instruction count
//   stat_j       in   32  J-type instruction count
//   stat_total   in   32  total instruction count
//   src_sel      in   3   source select (see seg7_pkg::src_e)
//   freeze       in   1   hold shown_value; also lights dp on digit 0
//   an           out  8   digit enables, active-low, bit k = digit k
//   seg          out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   shown_value  out  32  word currently on the display
// -----------------------------------------------------------------------------
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV       = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hex_in,
    input  logic [31:0] stat_r,
    input  logic [31:0] stat_i,
    input  logic [31:0] stat_j,
    input  logic [31:0] stat_total,
    input  logic [2:0]  src_sel,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [31:0] shown_value
);

    localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST  = PW'(CLK_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]      AN_RESET = 8'hFE;

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic          primed;

    logic          tick;
    logic          wrap;
    logic          load;
    logic [31:0]   src_value;
    logic [31:0]   next_shown;
    logic [2:0]    next_idx;
    logic [4:0]    bit_base;
    logic [3:0]    nibble;
    logic [6:0]    pattern;
    logic          blank;
    logic          dp_n;

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // The first free cycle after reset primes the display regardless of
    // freeze; prime and wrap share one load term, so a coincidence of the two
    // still loads exactly once.
    assign load = !primed || (wrap && !freeze);

    always_comb begin
        src_value = hex_in;
        case (src_sel)
            SRC_R:     src_value = stat_r;
            SRC_I:     src_value = stat_i;
            SRC_J:     src_value = stat_j;
            SRC_TOTAL: src_value = stat_total;
            default:   src_value = hex_in;
        endcase
    end

    // an/seg are registered from the values idx and shown_value take on this
    // same edge, so the digit slot and its contents change together.
    assign next_idx   = tick ? idx + 3'd1 : idx;
    assign next_shown = load ? src_value : shown_value;
    assign bit_base   = {next_idx, 2'b00};
    assign nibble     = next_shown[bit_base +: 4];

    // A digit is a leading zero when it and everything above it are zero;
    // digit 0 always shows so the value 0 still reads as "0".
    assign blank = BLANK_LEADING && (next_idx != 3'd0)
                   && ((next_shown >> bit_base) == 32'd0);

    // dp marks "frozen" on the rightmost digit only.
    assign dp_n = !((next_idx == 3'd0) && freeze);

    hex7seg_decoder u_decoder (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the pre-edge values.
        if (rst) begin
            prescaler   <= '0;
            idx         <= '0;
            primed      <= 1'b0;
            shown_value <= '0;
            an          <= AN_RESET;
            seg         <= SEG_ZERO;
        end else begin
            prescaler   <= tick ? '0 : prescaler + PW'(1);
            idx         <= next_idx;
            primed      <= 1'b1;
            shown_value <= next_shown;
            if (blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
            end else begin
                an  <= ~(8'd1 << next_idx);
                seg <= {dp_n, pattern};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
// Three instances share clk/rst:
//   inst 0 (u_a): CLK_DIV = 4, blanking on  - main scenario (sources, freeze, reset)
//   inst 1 (u_b): CLK_DIV = 4, blanking off - value 0 on all eight digits
//   inst 2 (u_c): CLK_DIV = 1, blanking on  - one digit per cycle
// Stimulus pushes hand-computed expectations tagged with the cycle they are
// due; the monitor compares them on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] shown;
        logic [7:0]  an;
        logic [7:0]  seg;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_hex;
    logic [31:0] stat_r;
    logic [31:0] stat_i;
    logic [31:0] stat_j;
    logic [31:0] stat_total;
    logic [2:0]  a_src;
    logic        a_freeze;
    logic [31:0] c_hex;
    logic [31:0] zero_word = 32'd0;
    logic [2:0]  zero_sel  = 3'd0;
    logic        zero_bit  = 1'b0;

    logic [7:0]  a_an, b_an, c_an;
    logic [7:0]  a_seg, b_seg, c_seg;
    logic [31:0] a_shown, b_shown, c_shown;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_display #(.CLK_DIV(4), .BLANK_LEADING(1'b1)) u_a (
        .clk(clk), .rst(rst), .hex_in(a_hex), .stat_r(stat_r), .stat_i(stat_i),
        .stat_j(stat_j), .stat_total(stat_total), .src_sel(a_src), .freeze(a_freeze),
        .an(a_an), .seg(a_seg), .shown_value(a_shown)
    );

    seg7_scan_display #(.CLK_DIV(4), .BLANK_LEADING(1'b0)) u_b (
        .clk(clk), .rst(rst), .hex_in(zero_word), .stat_r(stat_r), .stat_i(stat_i),
        .stat_j(stat_j), .stat_total(stat_total), .src_sel(zero_sel), .freeze(zero_bit),
        .an(b_an), .seg(b_seg), .shown_value(b_shown)
    );

    seg7_scan_display #(.CLK_DIV(1), .BLANK_LEADING(1'b1)) u_c (
        .clk(clk), .rst(rst), .hex_in(c_hex), .stat_r(stat_r), .stat_i(stat_i),
        .stat_j(stat_j), .stat_total(stat_total), .src_sel(zero_sel), .freeze(zero_bit),
        .an(c_an), .seg(c_seg), .shown_value(c_shown)
    );

    task automatic expect_at(input int inst, input int c, input logic [31:0] shown,
                             input logic [7:0] an_e, input logic [7:0] seg_e,
                             input string name);
        exp_t e;
        e.inst  = inst;
        e.cyc   = c;
        e.shown = shown;
        e.an    = an_e;
        e.seg   = seg_e;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e, input bit late);
        logic [31:0] got_shown;
        logic [7:0]  got_an;
        logic [7:0]  got_seg;
        case (e.inst)
            0:       begin got_shown = a_shown; got_an = a_an; got_seg = a_seg; end
            1:       begin got_shown = b_shown; got_an = b_an; got_seg = b_seg; end
            default: begin got_shown = c_shown; got_an = c_an; got_seg = c_seg; end
        endcase
        n_checks++;
        if (late || got_shown !== e.shown || got_an !== e.an || got_seg !== e.seg) begin
            n_fail++;
            $display("FAIL %s (inst %0d, cycle %0d%s): got shown=%h an=%h seg=%h, want shown=%h an=%h seg=%h",
                     e.name, e.inst, e.cyc, late ? ", missed" : "",
                     got_shown, got_an, got_seg, e.shown, e.an, e.seg);
        end
    endtask

    always @(negedge clk) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                check(sb[i], sb[i].cyc < cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic at_cycle(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst        = 1'b1;
        a_hex      = 32'h0000_1234;
        a_src      = 3'd0;
        a_freeze   = 1'b0;
        stat_r     = 32'h1111_1111;
        stat_i     = 32'h2222_2222;
        stat_j     = 32'h3333_3333;
        stat_total = 32'hDEAD_BEEF;
        c_hex      = 32'h8765_4321;

        // Reset values while rst is held.
        for (int k = 0; k < 3; k++) begin
            expect_at(k, 2, 32'h0, 8'hFE, 8'hC0, "reset_hold");
            expect_at(k, 3, 32'h0, 8'hFE, 8'hC0, "reset_hold");
        end

        // inst 0: prime on cycle 4, ticks at 7, 11, 15, ... (3 + 4m), wrap at 35.
        expect_at(0,  4, 32'h1234, 8'hFE, 8'h99, "prime_digit0");
        expect_at(0,  6, 32'h1234, 8'hFE, 8'h99, "slot0_hold");
        expect_at(0,  7, 32'h1234, 8'hFD, 8'hB0, "digit1_3");
        expect_at(0, 11, 32'h1234, 8'hFB, 8'hA4, "digit2_2");
        expect_at(0, 15, 32'h1234, 8'hF7, 8'hF9, "digit3_1");
        expect_at(0, 19, 32'h1234, 8'hFF, 8'hFF, "digit4_blank");
        expect_at(0, 31, 32'h1234, 8'hFF, 8'hFF, "digit7_blank");
        expect_at(0, 35, 32'h1234, 8'hFE, 8'h99, "wrap_digit0");

        // inst 1: no blanking, all eight digits show 0 in turn.
        for (int m = 0; m <= 8; m++) begin
            logic [7:0] an_e;
            an_e = ~(8'd1 << (m % 8));
            expect_at(1, (m == 0) ? 4 : 3 + 4 * m, 32'h0, an_e, 8'hC0, "noblank_zero");
        end

        // inst 2: prime and tick on cycle 4 (idx -> 1), wrap loads at 11, 19, ...
        expect_at(2,  4, 32'h8765_4321, 8'hFD, 8'hA4, "div1_prime");
        expect_at(2,  5, 32'h8765_4321, 8'hFB, 8'hB0, "div1_step");
        expect_at(2, 18, 32'h8765_4321, 8'h7F, 8'h80, "div1_old_digit7");
        expect_at(2, 19, 32'h0000_00C9, 8'hFE, 8'h90, "div1_wrap_load");
        expect_at(2, 20, 32'h0000_00C9, 8'hFD, 8'hC6, "div1_digit1_c");
        expect_at(2, 21, 32'h0000_00C9, 8'hFF, 8'hFF, "div1_digit2_blank");

        at_cycle(3);
        rst = 1'b0;

        at_cycle(12);
        c_hex = 32'h0000_00C9;

        // Mid-frame source switch: no effect until the wrap at 67.
        at_cycle(40);
        a_src = 3'd4;
        expect_at(0, 66, 32'h1234,      8'hFF, 8'hFF, "switch_before_wrap");
        expect_at(0, 67, 32'hDEAD_BEEF, 8'hFE, 8'h8E, "switch_wrap_f");
        expect_at(0, 71, 32'hDEAD_BEEF, 8'hFD, 8'h86, "switch_digit1_e");
        expect_at(0, 95, 32'hDEAD_BEEF, 8'h7F, 8'hA1, "switch_digit7_d");

        // Freeze with a new source value: held over the wraps at 99, 131, 163.
        at_cycle(80);
        a_src    = 3'd0;
        a_hex    = 32'h0000_00A5;
        a_freeze = 1'b1;
        expect_at(0,  98, 32'hDEAD_BEEF, 8'h7F, 8'hA1, "freeze_dp_off_digit7");
        expect_at(0,  99, 32'hDEAD_BEEF, 8'hFE, 8'h0E, "freeze_wrap1_dp");
        expect_at(0, 131, 32'hDEAD_BEEF, 8'hFE, 8'h0E, "freeze_wrap2_dp");
        expect_at(0, 163, 32'hDEAD_BEEF, 8'hFE, 8'h0E, "freeze_wrap3_dp");

        at_cycle(170);
        a_freeze = 1'b0;
        expect_at(0, 172, 32'hDEAD_BEEF, 8'hFB, 8'h86, "unfreeze_still_old");
        expect_at(0, 195, 32'h0000_00A5, 8'hFE, 8'h92, "unfreeze_wrap_load");
        expect_at(0, 199, 32'h0000_00A5, 8'hFD, 8'h88, "unfreeze_digit1_a");
        expect_at(0, 203, 32'h0000_00A5, 8'hFF, 8'hFF, "unfreeze_digit2_blank");

        // Reset pulse while inst 0 sits on digit 5, with freeze high.
        at_cycle(216);
        rst      = 1'b1;
        a_freeze = 1'b1;
        a_hex    = 32'h0000_0042;
        for (int k = 0; k < 3; k++)
            expect_at(k, 217, 32'h0, 8'hFE, 8'hC0, "midframe_reset");
        expect_at(0, 218, 32'h0000_0042, 8'hFE, 8'h24, "reprime_frozen_dp");
        expect_at(1, 218, 32'h0,         8'hFE, 8'hC0, "reprime_zero");
        expect_at(2, 218, 32'h0000_00C9, 8'hFD, 8'hC6, "reprime_div1");

        at_cycle(217);
        rst = 1'b0;

        at_cycle(218);
        a_freeze = 1'b0;
        expect_at(0, 219, 32'h0000_0042, 8'hFE, 8'hA4, "dp_clears_next_cycle");
        expect_at(0, 221, 32'h0000_0042, 8'hFD, 8'h99, "reprime_digit1_4");
        expect_at(0, 225, 32'h0000_0042, 8'hFF, 8'hFF, "reprime_digit2_blank");

        at_cycle(230);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
